// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver. Frame is one start bit, p_WORD_LEN+1
// data bits LSB first, one stop bit; each bit lasts p_CLK_DIV+1 clocks.
module uart_rx #(
    parameter int unsigned p_CLK_DIV  = 104,
    parameter int unsigned p_WORD_LEN = 8
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_rx,
    output logic [p_WORD_LEN:0] o_data,
    output logic                o_dv,
    output logic                o_frame_err,
    output logic                o_active
);

    localparam int unsigned WORD_W = p_WORD_LEN + 1;
    localparam int unsigned CNT_W  = (p_CLK_DIV > 0) ? $clog2(p_CLK_DIV + 1) : 1;
    localparam int unsigned BIT_W  = (p_WORD_LEN > 0) ? $clog2(p_WORD_LEN + 1) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(p_CLK_DIV);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(p_CLK_DIV / 2);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(p_WORD_LEN);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    logic              rx_meta;
    logic              rx_s;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [WORD_W-1:0] shift_q, shift_d;
    logic [WORD_W-1:0] data_d;
    logic              dv_d;
    logic              ferr_d;
    logic              active_d;

    // Two-flop synchronizer; the line idles high so both flops reset to 1.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= i_rx;
            rx_s    <= rx_meta;
        end
    end

    // Next-state and next-output logic for the frame sequencer.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        data_d   = o_data;
        dv_d     = 1'b0;
        ferr_d   = o_frame_err;
        active_d = o_active;

        case (state_q)
            S_IDLE: begin
                cnt_d    = '0;
                bit_d    = '0;
                active_d = 1'b0;
                if (!rx_s) begin
                    state_d  = S_START;
                    active_d = 1'b1;
                end
            end

            S_START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d = '0;
                    if (!rx_s) begin
                        state_d = S_DATA;
                    end else begin
                        state_d  = S_IDLE;
                        active_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d          = '0;
                    shift_d[bit_q] = rx_s;
                    if (bit_q == BIT_LAST) begin
                        bit_d   = '0;
                        state_d = S_STOP;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d  = '0;
                    data_d = shift_q;
                    dv_d   = 1'b1;
                    ferr_d = ~rx_s;
                    if (rx_s) begin
                        state_d  = S_IDLE;
                        active_d = 1'b0;
                    end else begin
                        state_d = S_BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            // A held-low line must not be decoded as a stream of zero words.
            S_BREAK: begin
                if (rx_s) begin
                    state_d  = S_IDLE;
                    active_d = 1'b0;
                end
            end

            default: begin
                state_d  = S_IDLE;
                cnt_d    = '0;
                bit_d    = '0;
                active_d = 1'b0;
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            o_data      <= '0;
            o_dv        <= 1'b0;
            o_frame_err <= 1'b0;
            o_active    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            o_data      <= data_d;
            o_dv        <= dv_d;
            o_frame_err <= ferr_d;
            o_active    <= active_d;
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: several uart_rx instances with different divider/word settings,
// driven by a bit-level transmitter model; a frame scoreboard predicts each
// o_dv cycle, word and error flag from the frame timing rules.
module tb_uart_rx;

    localparam int NI = 7;
    localparam int unsigned CD [NI] = '{7, 104, 3, 3, 16, 16, 104};
    localparam int unsigned WL [NI] = '{8, 8, 7, 8, 7, 8, 7};

    typedef struct {
        int         inst;
        longint     cyc;
        logic [8:0] data;
        logic       ferr;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx   [NI];
    logic       dv   [NI];
    logic [8:0] dat  [NI];
    logic       ferr [NI];
    logic       act  [NI];

    longint     cyc = 0;
    int         n_cmp = 0;
    int         n_fail = 0;

    exp_t       exp_q[$];
    logic [8:0] exp_data [NI];
    logic       exp_ferr [NI];

    int         dv_cnt       [NI];
    int         ferr_cnt     [NI];
    int         act_rise     [NI];
    logic       act_prev     [NI];
    longint     last_dv_cyc  [NI];
    logic [8:0] last_dv_data [NI];
    logic       last_dv_ferr [NI];
    logic       last_dv_act  [NI];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        logic [WL[g]:0] d;
        uart_rx #(
            .p_CLK_DIV  (CD[g]),
            .p_WORD_LEN (WL[g])
        ) u_dut (
            .i_clk       (clk),
            .i_rst_n     (rst_n),
            .i_rx        (rx[g]),
            .o_data      (d),
            .o_dv        (dv[g]),
            .o_frame_err (ferr[g]),
            .o_active    (act[g])
        );
        assign dat[g] = 9'(d);
    end

    // Clocks from the line falling before edge k to the o_dv edge.
    function automatic longint lat(input int i);
        return longint'(3 + CD[i] / 2 + (WL[i] + 2) * (CD[i] + 1));
    endfunction

    // Scoreboard compare: every cycle, every instance.
    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            int   idx;
            logic hit;
            idx = -1;
            hit = 1'b0;
            if (!rst_n) begin
                exp_data[i] = '0;
                exp_ferr[i] = 1'b0;
                act_prev[i] = 1'b0;
                n_cmp++;
                if (dv[i] !== 1'b0 || dat[i] !== 9'h000 || ferr[i] !== 1'b0 || act[i] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL reset_outputs inst%0d cyc%0d: dv=%b data=%h ferr=%b act=%b, want all 0", i, cyc, dv[i], dat[i], ferr[i], act[i]);
                end
            end else begin
                for (int j = 0; j < exp_q.size(); j++) begin
                    if (idx < 0 && exp_q[j].inst == i && exp_q[j].cyc == cyc) idx = j;
                end
                if (idx >= 0) begin
                    hit         = 1'b1;
                    exp_data[i] = exp_q[idx].data;
                    exp_ferr[i] = exp_q[idx].ferr;
                    exp_q.delete(idx);
                end
                n_cmp++;
                if (dv[i] !== hit || dat[i] !== exp_data[i] || ferr[i] !== exp_ferr[i]) begin
                    n_fail++;
                    $display("FAIL model inst%0d cyc%0d: dv=%b data=%h ferr=%b, want dv=%b data=%h ferr=%b", i, cyc, dv[i], dat[i], ferr[i], hit, exp_data[i], exp_ferr[i]);
                end
                if (dv[i] === 1'b1) begin
                    dv_cnt[i]++;
                    if (ferr[i] === 1'b1) ferr_cnt[i]++;
                    last_dv_cyc[i]  = cyc;
                    last_dv_data[i] = dat[i];
                    last_dv_ferr[i] = ferr[i];
                    last_dv_act[i]  = act[i];
                end
                if (act[i] === 1'b1 && act_prev[i] !== 1'b1) act_rise[i]++;
                act_prev[i] = act[i];
            end
        end
        if (!rst_n) exp_q.delete();
    end

    task automatic check(input string name, input longint got, input longint want);
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic hold(input int i);
        repeat (CD[i] + 1) @(posedge clk);
        #1;
    endtask

    // Transmit one frame on instance i; the line is left at the stop value.
    task automatic send_frame(input int i, input logic [8:0] w, input logic stop_bit);
        exp_t       e;
        logic [8:0] m;
        m      = 9'((1 << (WL[i] + 1)) - 1);
        rx[i]  = 1'b0;
        e.inst = i;
        e.cyc  = cyc + 1 + lat(i);
        e.data = w & m;
        e.ferr = ~stop_bit;
        exp_q.push_back(e);
        hold(i);
        for (int b = 0; b <= int'(WL[i]); b++) begin
            rx[i] = w[b];
            hold(i);
        end
        rx[i] = stop_bit;
        hold(i);
    endtask

    task automatic drain(input int limit);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < limit) begin
            @(posedge clk);
            n++;
        end
        #1;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d frames still pending after %0d cycles", exp_q.size(), limit);
            exp_q.delete();
        end
        idle(4);
    endtask

    initial begin
        longint k;
        int     base_dv;
        int     base_act;
        int     base6 [NI];
        int     basef6 [NI];

        rst_n = 1'b0;
        for (int i = 0; i < NI; i++) begin
            rx[i]       = 1'b1;
            dv_cnt[i]   = 0;
            ferr_cnt[i] = 0;
            act_rise[i] = 0;
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(3);

        // Reset state
        for (int i = 0; i < NI; i++) begin
            check("reset_data", dat[i], 0);
            check("reset_dv", dv[i], 0);
            check("reset_active", act[i], 0);
        end

        // Default configuration, single frame, latency pinned
        base_dv = dv_cnt[1];
        k = cyc + 1;
        send_frame(1, 9'h1A5, 1'b1);
        drain(2000);
        check("t1_dv_count", dv_cnt[1] - base_dv, 1);
        check("t1_latency", last_dv_cyc[1] - k, 1105);
        check("t1_data", last_dv_data[1], 9'h1A5);
        check("t1_ferr", last_dv_ferr[1], 0);
        check("t1_active_low_at_dv", last_dv_act[1], 0);

        // False start rejected, data held, following frame good
        send_frame(0, 9'h0C3, 1'b1);
        drain(200);
        base_dv  = dv_cnt[0];
        base_act = act_rise[0];
        rx[0] = 1'b0;
        idle(2);
        rx[0] = 1'b1;
        idle(20);
        check("t2_active_pulse", act_rise[0] - base_act, 1);
        check("t2_no_dv", dv_cnt[0] - base_dv, 0);
        check("t2_data_held", dat[0], 9'h0C3);
        check("t2_active_idle", act[0], 0);
        send_frame(0, 9'h055, 1'b1);
        drain(200);
        check("t2_next_dv", dv_cnt[0] - base_dv, 1);
        check("t2_next_data", last_dv_data[0], 9'h055);

        // Framing error followed by a held-low line
        base_dv = dv_cnt[0];
        send_frame(0, 9'h0FF, 1'b0);
        idle(30);
        drain(200);
        check("t3_dv_count", dv_cnt[0] - base_dv, 1);
        check("t3_ferr", last_dv_ferr[0], 1);
        check("t3_data", last_dv_data[0], 9'h0FF);
        check("t3_break_active", act[0], 1);
        rx[0] = 1'b1;
        idle(10);
        check("t3_break_released", act[0], 0);
        check("t3_no_extra_dv", dv_cnt[0] - base_dv, 1);
        send_frame(0, 9'h033, 1'b1);
        drain(200);
        check("t3_recover_data", last_dv_data[0], 9'h033);
        check("t3_recover_ferr", last_dv_ferr[0], 0);

        // Back-to-back frames with no idle gap
        base_dv = dv_cnt[0];
        send_frame(0, 9'h000, 1'b1);
        send_frame(0, 9'h1FF, 1'b1);
        send_frame(0, 9'h12C, 1'b1);
        drain(200);
        check("t4_dv_count", dv_cnt[0] - base_dv, 3);
        check("t4_last_data", last_dv_data[0], 9'h12C);

        // Reset in the middle of data bit 4 (bits 4..8 and stop are high)
        base_dv = dv_cnt[0];
        fork
            send_frame(0, 9'h1F0, 1'b1);
        join_none
        idle(5 * (CD[0] + 1) + (CD[0] + 1) / 2);
        rst_n = 1'b0;
        #1;
        check("t5_async_data", dat[0], 0);
        check("t5_async_active", act[0], 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        wait fork;
        idle(5);
        check("t5_no_partial_dv", dv_cnt[0] - base_dv, 0);
        send_frame(0, 9'h0A3, 1'b1);
        drain(200);
        check("t5_next_dv", dv_cnt[0] - base_dv, 1);
        check("t5_next_data", last_dv_data[0], 9'h0A3);

        // Parameter sweep with random back-to-back words
        for (int i = 0; i < NI; i++) begin
            base6[i]  = dv_cnt[i];
            basef6[i] = ferr_cnt[i];
        end
        for (int i = 1; i < NI; i++) begin
            fork
                automatic int ii = i;
                begin
                    for (int n = 0; n < 5; n++) send_frame(ii, 9'($urandom_range(0, 511)), 1'b1);
                end
            join_none
        end
        wait fork;
        drain(3000);
        for (int i = 1; i < NI; i++) begin
            check("t6_frames", dv_cnt[i] - base6[i], 5);
            check("t6_frame_errs", ferr_cnt[i] - basef6[i], 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        n_fail++;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receiver; the receive end of the team's UART link, paired with uart_tx.
- Oversamples the asynchronous rx line with the internal clock.
- Frame: start bit, p_WORD_LEN+1 data bits LSB first (parity, if used, is the top bit), one stop bit.
- Presents each received word with a one-cycle valid strobe and a frame-error flag to the downstream consumer (command decoder / FIFO).

Parameters:
- p_CLK_DIV, 104: clock divider ratio. One bit period = p_CLK_DIV+1 clocks, matching uart_tx.
- p_WORD_LEN, 8: index of the top data bit; word width is p_WORD_LEN+1 bits.

Ports:
- i_clk, input, 1: clock; all state updates on the rising edge.
- i_rst_n, input, 1: asynchronous reset, active-low.
- i_rx, input, 1: serial rx line; asynchronous, idles high.
- o_data, output, p_WORD_LEN+1: last received word; holds until the next frame completes.
- o_dv, output, 1: one-cycle strobe; a frame has completed and o_data/o_frame_err are updated.
- o_frame_err, output, 1: qualified by o_dv; 1 if the stop bit sampled low.
- o_active, output, 1: high from start-bit detection until the frame ends or a false start is rejected.

Behaviour:
- Reset (i_rst_n=0, asynchronous):
  - Outputs: o_data=0, o_dv=0, o_frame_err=0, o_active=0.
  - Internal: state=IDLE, counters=0, both synchronizer flops=1.
  - Reset mid-frame abandons the frame with no o_dv.
  - After release, reception restarts only on a new high-to-low transition seen in IDLE.
- Synchronizer: two-flop chain on i_rx. All logic uses the second flop (rx_s). Latency is 2 cycles.
- Definitions: H = p_CLK_DIV/2 (integer floor). The clock counter is wide enough for p_CLK_DIV. The bit counter is wide enough for p_WORD_LEN.
- IDLE:
  - o_active=0, counters cleared.
  - rx_s=0 -> START, o_active=1.
- START:
  - Count 0..H.
  - At count==H: rx_s=0 -> DATA, count=0. rx_s=1 -> false start, back to IDLE, o_active=0, no o_dv.
- DATA:
  - Count 0..p_CLK_DIV. At count==p_CLK_DIV, shift rx_s into bit[bit_count], count=0.
  - Sampling points are therefore spaced p_CLK_DIV+1 clocks apart, at mid-bit.
  - After bit p_WORD_LEN is sampled -> STOP, bit_count=0.
- STOP:
  - Count 0..p_CLK_DIV. At count==p_CLK_DIV, sample rx_s. On that edge: o_data <= shift register, o_dv <= 1, o_frame_err <= ~rx_s.
  - rx_s=1 -> IDLE, o_active=0.
  - rx_s=0 (framing error or break) -> BREAK.
- BREAK:
  - o_active stays 1; wait until rx_s=1, then IDLE.
  - Prevents a held-low line from being decoded as 0x000 frames.
- o_dv: high for exactly one cycle per completed frame, never on a false start or reset. o_frame_err is only meaningful when o_dv=1; it holds its value otherwise.
- Latency: let the line fall before edge k.
  - The START check happens at edge k+3+H.
  - Data bit i is sampled at edge k+3+H+(i+1)(p_CLK_DIV+1).
  - The stop bit is sampled at edge k+3+H+(p_WORD_LEN+2)(p_CLK_DIV+1); o_dv is high in the following cycle.
  - With defaults this is edge k+1105.
- Back-to-back frames: IDLE is re-entered about half a bit period before the end of the stop bit. A start edge immediately after the stop bit must be caught, so there is no dead time beyond 1 cycle.
- Unused state encodings -> IDLE.

Test Plan:
1. Defaults, uart_tx drives 9'h1A5 -> exactly one o_dv pulse, o_data=9'h1A5, o_frame_err=0, o_dv at edge k+1105, o_active low in the cycle after the final sample.
2. p_CLK_DIV=7, i_rx low for 2 cycles, then high -> o_active pulses, no o_dv, o_data unchanged; a following valid frame 9'h055 is received correctly.
3. p_CLK_DIV=7, frame 9'h0FF with stop bit driven low, then line held low for 30 cycles -> one o_dv with o_frame_err=1, o_data=9'h0FF, no further o_dv until the line returns high and a new frame is sent.
4. Back-to-back uart_tx frames 9'h000, 9'h1FF, 9'h12C, next i_dv issued immediately on o_done -> three o_dv pulses in order with matching o_data, all o_frame_err=0.
5. Assert i_rst_n=0 for 3 cycles midway through data bit 4 -> outputs clear immediately (async), no o_dv for the partial frame, the next full frame 9'h0A3 is received correctly.
6. Sweep p_CLK_DIV in {3, 16, 104} and p_WORD_LEN in {7, 8} with random words against uart_tx -> all words match, zero frame errors.
